memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Y86-64 SEQ memory stage, directly downstream of execute.
- Consumes icode, valE and valA from execute, plus valP and fetch error flags carried alongside.
- Performs the data-memory read or write, produces valM, and computes the instruction status Stat for writeback and PC update.
- Owns the byte-addressed data memory. A sticky halt FSM blocks all further memory activity after any non-AOK status.

Parameters:
- MEM_BYTES, 1024: data memory size in bytes; must be a multiple of 8 and at least 16.
- ADDR_W, 64: address width. Addresses are the full 64-bit valE/valA.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  one instruction presented this cycle
- in_ready  out  1  stage can accept (high only in RUN)
- icode  in  4  instruction code
- valE  in  64  ALU result from execute
- valA  in  64  register operand A
- valP  in  64  incremented PC
- imem_error  in  1  fetch address error
- instr_valid  in  1  fetch decoded a legal icode
- ld_en  in  1  preload write strobe (bench/boot)
- ld_addr  in  64  preload byte address, 8-aligned
- ld_data  in  64  preload word
- out_valid  out  1  result valid, one-cycle pulse
- valM  out  64  loaded word
- stat  out  3  1=AOK 2=HLT 3=ADR 4=INS
- dmem_error  out  1  data access out of range or misaligned
- halted  out  1  FSM in HALTED

Behaviour:
- Reset, synchronous:
  - Outputs: out_valid=0, valM=0, stat=AOK (1), dmem_error=0, halted=0.
  - FSM goes to RUN.
  - Memory contents are unchanged.
- FSM:
  - RUN: in_ready=1.
  - HALTED: in_ready=0, halted=1; exits only on rst.
  - Transition from RUN to HALTED on the edge that registers a stat other than AOK.
- Access decode, combinational from icode:
  - write to valE, data valA: rmmovq (4), pushq (A).
  - write to valE, data valP: call (8).
  - read from valE: mrmovq (5).
  - read from valA: popq (B), ret (9).
  - All other icodes: no access.
- Memory format: 8-byte little-endian words.
  - An access is legal iff addr[2:0]==0 and addr <= MEM_BYTES-8, evaluated without 64-bit wrap.
  - An illegal access asserts dmem_error. It performs no write, and valM=0.
- Latency: 1 cycle. An instruction accepted at edge N (in_valid && in_ready) produces, at edge N:
  - the write commit,
  - out_valid=1,
  - valM, stat and dmem_error registered together.
  - out_valid=0 on every other cycle.
  - in_valid while HALTED is ignored: no write, no out_valid.
- Read data is the memory content before any write in the same cycle. A read and a write never occur in the same instruction.
- stat priority:
  - ADR if imem_error or dmem_error,
  - else INS if !instr_valid,
  - else HLT if icode==0,
  - else AOK.
- valM holds its last value when there is no read and no error.
- Preload port:
  - ld_en writes ld_data at ld_addr when ld_addr is legal; otherwise it is silently ignored.
  - Allowed in any FSM state.
  - If ld_en coincides with an accepted stage write, the stage write wins at its address. Both commit if the addresses differ.
- rst asserted together with in_valid: reset wins. No write, out_valid=0.

Decomposition:
- Shared package y86_pkg:
  - icode constants (IHALT..IPOPQ),
  - stat constants (SAOK=1, SHLT=2, SADR=3, SINS=4),
  - 8-byte word width constant.
- One sub-module, data_memory: byte array with one 8-byte aligned read port, one stage write port, the preload write port with write priority as above, and a legality flag output.
- memory_stage holds access decode, the status logic and the FSM.

Test Plan:
1. Preload word 0x0123456789ABCDEF at addr 0x40, then mrmovq with valE=0x40 → next edge out_valid=1, valM=0x0123456789ABCDEF, stat=1, dmem_error=0.
2. rmmovq valE=0x80 valA=0xDEADBEEF, then mrmovq valE=0x80 → valM=0x00000000DEADBEEF. Then call with valE=0x88 valP=0x123, then ret with valA=0x88 → valM=0x123.
3. mrmovq valE=0x3FC (MEM_BYTES=1024) → dmem_error=1, stat=3, valM=0, halted=1, in_ready=0. A following rmmovq valE=0x10 does not write; preload read-back of 0x10 is unchanged.
4. icode=0 (halt) → stat=2, halted=1. instr_valid=0 on a fresh run → stat=4. imem_error=1 together with instr_valid=0 → stat=3.
5. rst asserted while in HALTED → next cycle halted=0, in_ready=1, stat=1, out_valid=0. rst together with an rmmovq to 0x20 → memory at 0x20 unchanged.
6. ld_en to 0x30 with data 0x1111, same cycle as pushq valE=0x30 valA=0x2222 → read-back of 0x30 returns 0x2222.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 definitions for the memory stage slice.
// - instruction codes IHALT..IPOPQ
// - instruction status codes SAOK/SHLT/SADR/SINS
// - data word geometry (8-byte little-endian words)
// - state encoding of the sticky halt FSM and the status priority helper
package y86_pkg;

  localparam int WORD_BYTES = 8;
  localparam int WORD_W     = 64;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } stage_state_e;

  // Address faults dominate illegal instructions, which dominate halt.
  function automatic logic [2:0] calc_stat(input logic       imem_err,
                                           input logic       dmem_err,
                                           input logic       instr_ok,
                                           input logic [3:0] ic);
    logic [2:0] s;
    if (imem_err || dmem_err) begin
      s = SADR;
    end else if (!instr_ok) begin
      s = SINS;
    end else if (ic == IHALT) begin
      s = SHLT;
    end else begin
      s = SAOK;
    end
    return s;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: execute-to-memory bundle plus the result/status returned
// by the memory stage and the preload (boot) write port.
//   master: upstream/bench side (drives instruction and preload fields)
//   slave : memory_stage side (drives in_ready and the registered results)
interface memory_stage_if;
  import y86_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode;
  logic [WORD_W-1:0] valE;
  logic [WORD_W-1:0] valA;
  logic [WORD_W-1:0] valP;
  logic              imem_error;
  logic              instr_valid;
  logic              ld_en;
  logic [WORD_W-1:0] ld_addr;
  logic [WORD_W-1:0] ld_data;
  logic              out_valid;
  logic [WORD_W-1:0] valM;
  logic [2:0]        stat;
  logic              dmem_error;
  logic              halted;

  modport master (
    output in_valid, icode, valE, valA, valP, imem_error, instr_valid,
           ld_en, ld_addr, ld_data,
    input  in_ready, out_valid, valM, stat, dmem_error, halted
  );

  modport slave (
    input  in_valid, icode, valE, valA, valP, imem_error, instr_valid,
           ld_en, ld_addr, ld_data,
    output in_ready, out_valid, valM, stat, dmem_error, halted
  );

endinterface

// File: rtl/data_memory.sv
// data_memory: byte-addressed data store holding 8-byte little-endian words.
//   acc_addr/rd_data : stage access address and combinational aligned read
//   acc_legal        : acc_addr is aligned and the whole word fits in memory
//   st_we/st_wdata   : stage write at acc_addr
//   ld_we/ld_addr/ld_wdata : preload write, ignored at illegal addresses
// A stage write and a preload to the same address in one cycle: stage wins.
// Contents are never reset.
module data_memory
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] acc_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              acc_legal,
  input  logic              st_we,
  input  logic [WORD_W-1:0] st_wdata,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WORD_W-1:0] ld_wdata
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - WORD_BYTES);

  // Full-width compare so addresses near 2^64 cannot wrap into range.
  function automatic logic is_legal(input logic [ADDR_W-1:0] a);
    return (a[2:0] == 3'b000) && (a <= LAST_WORD);
  endfunction

  logic [7:0]       mem_q [MEM_BYTES];
  logic [IDX_W-1:0] acc_idx_s;
  logic [IDX_W-1:0] ld_idx_s;
  logic             ld_legal_s;

  assign acc_idx_s  = acc_addr[IDX_W-1:0];
  assign ld_idx_s   = ld_addr[IDX_W-1:0];
  assign acc_legal  = is_legal(acc_addr);
  assign ld_legal_s = is_legal(ld_addr);

  // Aligned little-endian word read; zero when the address is illegal.
  always_comb begin
    rd_data = '0;
    if (acc_legal) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        rd_data[8*b +: 8] = mem_q[acc_idx_s + IDX_W'(b)];
      end
    end else begin
      rd_data = '0;
    end
  end

  // Byte writes; the stage write is issued last so it overrides the preload.
  always_ff @(posedge clk) begin
    if (ld_we && ld_legal_s) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        mem_q[ld_idx_s + IDX_W'(b)] <= ld_wdata[8*b +: 8];
      end
    end
    if (st_we && acc_legal) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        mem_q[acc_idx_s + IDX_W'(b)] <= st_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: Y86-64 SEQ memory stage.
//   clk, rst : clock and synchronous active-high reset
//   bus      : memory_stage_if.slave -- instruction fields from execute
//              (icode, valE, valA, valP, imem_error, instr_valid, in_valid),
//              preload port (ld_*), and registered results
//              (out_valid, valM, stat, dmem_error) plus in_ready/halted.
// Decodes the memory access from icode, performs it in data_memory, forms
// the instruction status and stops accepting work after any non-AOK status
// until reset.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input logic clk,
  input logic rst,
  memory_stage_if.slave bus
);

  stage_state_e      state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] valm_q, valm_d;
  logic [2:0]        stat_q, stat_d;
  logic              dmem_error_q, dmem_error_d;

  logic              acc_rd_s;
  logic              acc_wr_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [WORD_W-1:0] acc_wdata_s;
  logic [WORD_W-1:0] rd_data_s;
  logic              acc_legal_s;
  logic              accept_s;
  logic              dmem_err_s;
  logic [2:0]        stat_s;

  // Access decode: which operand addresses memory and what gets stored.
  always_comb begin
    acc_rd_s    = 1'b0;
    acc_wr_s    = 1'b0;
    acc_addr_s  = bus.valE;
    acc_wdata_s = bus.valA;
    case (bus.icode)
      IRMMOVQ, IPUSHQ: acc_wr_s = 1'b1;
      ICALL: begin
        acc_wr_s    = 1'b1;
        acc_wdata_s = bus.valP;
      end
      IMRMOVQ: acc_rd_s = 1'b1;
      IPOPQ, IRET: begin
        acc_rd_s   = 1'b1;
        acc_addr_s = bus.valA;
      end
      IHALT, INOP, IRRMOVQ, IIRMOVQ, IOPQ, IJXX: begin
        acc_rd_s = 1'b0;
        acc_wr_s = 1'b0;
      end
      default: begin
        acc_rd_s = 1'b0;
        acc_wr_s = 1'b0;
      end
    endcase
  end

  // Reset beats a simultaneous instruction: nothing is accepted that cycle.
  assign accept_s   = bus.in_valid && (state_q == ST_RUN) && !rst;
  assign dmem_err_s = (acc_rd_s || acc_wr_s) && !acc_legal_s;
  assign stat_s     = calc_stat(bus.imem_error, dmem_err_s, bus.instr_valid, bus.icode);

  data_memory #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_dmem (
    .clk       (clk),
    .acc_addr  (acc_addr_s),
    .rd_data   (rd_data_s),
    .acc_legal (acc_legal_s),
    .st_we     (accept_s && acc_wr_s),
    .st_wdata  (acc_wdata_s),
    .ld_we     (bus.ld_en),
    .ld_addr   (bus.ld_addr),
    .ld_wdata  (bus.ld_data)
  );

  // Next-state and result computation for the halt FSM.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = 1'b0;
    valm_d       = valm_q;
    stat_d       = stat_q;
    dmem_error_d = dmem_error_q;
    if (accept_s) begin
      out_valid_d  = 1'b1;
      stat_d       = stat_s;
      dmem_error_d = dmem_err_s;
      if (dmem_err_s) begin
        valm_d = '0;
      end else if (acc_rd_s) begin
        valm_d = rd_data_s;
      end else begin
        valm_d = valm_q;
      end
    end else begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      ST_RUN: begin
        if (accept_s && (stat_s != SAOK)) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_HALTED;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      out_valid_q  <= 1'b0;
      valm_q       <= '0;
      stat_q       <= SAOK;
      dmem_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      valm_q       <= valm_d;
      stat_q       <= stat_d;
      dmem_error_q <= dmem_error_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_RUN);
  assign bus.halted     = (state_q == ST_HALTED);
  assign bus.out_valid  = out_valid_q;
  assign bus.valM       = valm_q;
  assign bus.stat       = stat_q;
  assign bus.dmem_error = dmem_error_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for memory_stage.
module tb_memory_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  memory_stage_if mif();

  memory_stage #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                      input logic [63:0] p, input logic imerr, input logic iv);
    mif.icode = ic; mif.valE = e; mif.valA = a; mif.valP = p;
    mif.imem_error = imerr; mif.instr_valid = iv; mif.in_valid = 1'b1;
    tick();
    mif.in_valid = 1'b0; mif.imem_error = 1'b0; mif.instr_valid = 1'b1;
  endtask

  task automatic preload(input logic [63:0] addr, input logic [63:0] data);
    mif.ld_en = 1'b1; mif.ld_addr = addr; mif.ld_data = data;
    tick();
    mif.ld_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++; if (mif.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b exp 0", mif.out_valid); end
    tests++; if (mif.valM !== 64'h0) begin fails++; $display("FAIL reset_valM got %h exp 0", mif.valM); end
    tests++; if (mif.stat !== 3'd1) begin fails++; $display("FAIL reset_stat got %0d exp 1", mif.stat); end
    tests++; if (mif.dmem_error !== 1'b0) begin fails++; $display("FAIL reset_dmem_error got %0b exp 0", mif.dmem_error); end
    tests++; if (mif.halted !== 1'b0 || mif.in_ready !== 1'b1) begin fails++; $display("FAIL reset_fsm got halted=%0b in_ready=%0b exp 0/1", mif.halted, mif.in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_load_read();
    preload(64'h40, 64'h0123456789ABCDEF);
    send(4'h5, 64'h40, 64'h0, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.out_valid !== 1'b1) begin fails++; $display("FAIL t1_out_valid got %0b exp 1", mif.out_valid); end
    tests++; if (mif.valM !== 64'h0123456789ABCDEF) begin fails++; $display("FAIL t1_valM got %h exp 0123456789abcdef", mif.valM); end
    tests++; if (mif.stat !== 3'd1 || mif.dmem_error !== 1'b0) begin fails++; $display("FAIL t1_stat got stat=%0d derr=%0b exp 1/0", mif.stat, mif.dmem_error); end
    tick();
    tests++; if (mif.out_valid !== 1'b0) begin fails++; $display("FAIL t1_pulse got %0b exp 0", mif.out_valid); end
  endtask

  task automatic test_store_call_ret();
    send(4'h4, 64'h80, 64'hDEADBEEF, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.stat !== 3'd1 || mif.out_valid !== 1'b1) begin fails++; $display("FAIL t2_rmmov got stat=%0d ov=%0b exp 1/1", mif.stat, mif.out_valid); end
    send(4'h5, 64'h80, 64'h0, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.valM !== 64'h00000000DEADBEEF) begin fails++; $display("FAIL t2_mrmov got %h exp 00000000deadbeef", mif.valM); end
    send(4'h8, 64'h88, 64'h5555, 64'h123, 1'b0, 1'b1);
    send(4'h9, 64'h90, 64'h88, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.valM !== 64'h123) begin fails++; $display("FAIL t2_ret got %h exp 123", mif.valM); end
    send(4'hA, 64'h98, 64'hCAFE, 64'h0, 1'b0, 1'b1);
    send(4'hB, 64'h0, 64'h98, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.valM !== 64'hCAFE) begin fails++; $display("FAIL t2_pop got %h exp cafe", mif.valM); end
    send(4'h1, 64'h3FC, 64'h3FC, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.valM !== 64'hCAFE || mif.stat !== 3'd1) begin fails++; $display("FAIL t2_nop_hold got valM=%h stat=%0d exp cafe/1", mif.valM, mif.stat); end
  endtask

  task automatic test_bad_addr();
    preload(64'h10, 64'h5555);
    preload(64'h3F8, 64'hA5A5_0000_1234_5678);
    send(4'h5, 64'h3F8, 64'h0, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.valM !== 64'hA5A5_0000_1234_5678 || mif.dmem_error !== 1'b0) begin fails++; $display("FAIL t3_last_word got valM=%h derr=%0b exp a5a5000012345678/0", mif.valM, mif.dmem_error); end
    send(4'h5, 64'h3FC, 64'h0, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.dmem_error !== 1'b1 || mif.stat !== 3'd3) begin fails++; $display("FAIL t3_err got derr=%0b stat=%0d exp 1/3", mif.dmem_error, mif.stat); end
    tests++; if (mif.valM !== 64'h0) begin fails++; $display("FAIL t3_valM got %h exp 0", mif.valM); end
    tests++; if (mif.halted !== 1'b1 || mif.in_ready !== 1'b0) begin fails++; $display("FAIL t3_halt got halted=%0b in_ready=%0b exp 1/0", mif.halted, mif.in_ready); end
    send(4'h4, 64'h10, 64'h9999, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.out_valid !== 1'b0 || mif.stat !== 3'd3) begin fails++; $display("FAIL t3_ignored got ov=%0b stat=%0d exp 0/3", mif.out_valid, mif.stat); end
    do_reset();
    send(4'h5, 64'h10, 64'h0, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.valM !== 64'h5555) begin fails++; $display("FAIL t3_no_write got %h exp 5555", mif.valM); end
    send(4'hB, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.dmem_error !== 1'b1 || mif.stat !== 3'd3) begin fails++; $display("FAIL t3_wrap got derr=%0b stat=%0d exp 1/3", mif.dmem_error, mif.stat); end
  endtask

  task automatic test_status();
    do_reset();
    send(4'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.stat !== 3'd2 || mif.halted !== 1'b1) begin fails++; $display("FAIL t4_hlt got stat=%0d halted=%0b exp 2/1", mif.stat, mif.halted); end
    do_reset();
    send(4'h1, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    tests++; if (mif.stat !== 3'd4 || mif.halted !== 1'b1) begin fails++; $display("FAIL t4_ins got stat=%0d halted=%0b exp 4/1", mif.stat, mif.halted); end
    do_reset();
    send(4'h1, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    tests++; if (mif.stat !== 3'd3 || mif.dmem_error !== 1'b0) begin fails++; $display("FAIL t4_adr got stat=%0d derr=%0b exp 3/0", mif.stat, mif.dmem_error); end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    tick();
    tests++; if (mif.halted !== 1'b0 || mif.in_ready !== 1'b1) begin fails++; $display("FAIL t5_unhalt got halted=%0b in_ready=%0b exp 0/1", mif.halted, mif.in_ready); end
    tests++; if (mif.stat !== 3'd1 || mif.out_valid !== 1'b0) begin fails++; $display("FAIL t5_stat got stat=%0d ov=%0b exp 1/0", mif.stat, mif.out_valid); end
    rst = 1'b0;
    preload(64'h20, 64'hAAAA);
    rst = 1'b1;
    send(4'h4, 64'h20, 64'hBBBB, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.out_valid !== 1'b0) begin fails++; $display("FAIL t5_rst_ov got %0b exp 0", mif.out_valid); end
    rst = 1'b0;
    send(4'h5, 64'h20, 64'h0, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.valM !== 64'hAAAA) begin fails++; $display("FAIL t5_rst_nowrite got %h exp aaaa", mif.valM); end
  endtask

  task automatic test_preload_collision();
    mif.ld_en = 1'b1; mif.ld_addr = 64'h30; mif.ld_data = 64'h1111;
    send(4'hA, 64'h30, 64'h2222, 64'h0, 1'b0, 1'b1);
    mif.ld_en = 1'b0;
    send(4'h5, 64'h30, 64'h0, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.valM !== 64'h2222) begin fails++; $display("FAIL t6_same_addr got %h exp 2222", mif.valM); end
    mif.ld_en = 1'b1; mif.ld_addr = 64'h48; mif.ld_data = 64'h4444;
    send(4'h4, 64'h50, 64'h5555, 64'h0, 1'b0, 1'b1);
    mif.ld_en = 1'b0;
    send(4'h5, 64'h48, 64'h0, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.valM !== 64'h4444) begin fails++; $display("FAIL t6_diff_ld got %h exp 4444", mif.valM); end
    send(4'h5, 64'h50, 64'h0, 64'h0, 1'b0, 1'b1);
    tests++; if (mif.valM !== 64'h5555) begin fails++; $display("FAIL t6_diff_st got %h exp 5555", mif.valM); end
  endtask

  initial begin
    mif.in_valid = 1'b0; mif.icode = 4'h1; mif.valE = 64'h0; mif.valA = 64'h0;
    mif.valP = 64'h0; mif.imem_error = 1'b0; mif.instr_valid = 1'b1;
    mif.ld_en = 1'b0; mif.ld_addr = 64'h0; mif.ld_data = 64'h0;
    test_reset();
    test_load_read();
    test_store_call_ret();
    test_bad_addr();
    test_status();
    test_reset_priority();
    test_preload_collision();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
